sum_accum: RTL and testbench

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/sum_accum_pkg.sv | 35 +++
 rtl/sum_accum_acc_add.sv | 31 +++
 rtl/sum_accum.sv | 187 ++++++++++++++++++
 tb/tb_sum_accum.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_accum_pkg.sv
// -----------------------------------------------------------------------------
// sum_accum_pkg
//
// Purpose : Shared types and defaults for the sum_accum batch accumulator.
//           Holds the FSM state encoding, the default batch length (N) and
//           accumulator width (ACC_W), and a small helper that sizes the beat
//           counter.
//
// Contents:
//   state_t          - IDLE / ACCUM / DONE batch states
//   N_DEFAULT        - default beats per batch
//   ACC_W_DEFAULT    - default accumulator / result width
//   BEAT_W           - width of the meaningful part of an adder word
//   cnt_width()      - bits needed to count 0..N inclusive
// -----------------------------------------------------------------------------
package sum_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int N_DEFAULT     = 4;
  localparam int ACC_W_DEFAULT = 8;

  // Upstream is a 2-bit ripple-carry adder: {cout, s[1:0]} spans 0..6.
  localparam int BEAT_W = 3;

  // The counter has to represent N itself (it reaches N on the last beat).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage : sum_accum_pkg

// File: rtl/sum_accum_acc_add.sv
// -----------------------------------------------------------------------------
// acc_add
//
// Purpose : Plain ACC_W-bit unsigned adder with carry out. Adds the running
//           accumulator and the zero-extended incoming beat; the carry out is
//           what the top level uses to flag overflow.
//
// Ports   :
//   i_acc   [ACC_W-1:0]  current accumulator value
//   i_beat  [ACC_W-1:0]  zero-extended beat value
//   o_sum   [ACC_W-1:0]  i_acc + i_beat modulo 2^ACC_W
//   o_carry              carry out of the ACC_W-bit add
// -----------------------------------------------------------------------------
module acc_add #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_beat,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_full;

  // One extra bit on each operand captures the carry without a separate
  // compare.
  assign w_full  = {1'b0, i_acc} + {1'b0, i_beat};
  assign o_sum   = w_full[ACC_W-1:0];
  assign o_carry = w_full[ACC_W];

endmodule : acc_add

// File: rtl/sum_accum.sv
// -----------------------------------------------------------------------------
// sum_accum
//
// Purpose : Collects N beats from a 2-bit ripple-carry adder (words 0..6),
//           sums them into an ACC_W-bit accumulator and presents the batch
//           total on a valid/ready output. Overflow (carry out of the
//           accumulator add) is recorded as a sticky flag for the batch.
//
// Build option:
//   SUM_ACCUM_SAT_EN  - when defined, the accumulator saturates to all-ones
//                       on the first carry and stays there for the rest of
//                       the batch. When undefined it wraps modulo 2^ACC_W.
//
// Parameters:
//   N      beats per batch (>= 1)
//   ACC_W  accumulator / result width (>= 4)
//
// Ports   :
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous batch abort; overrides every handshake
//   in_valid   upstream beat valid
//   in_ready   beat can be accepted this cycle (not in DONE)
//   in_data    adder word {0, cout, s[1:0]}; bit 3 is ignored
//   out_valid  batch total available
//   out_ready  downstream consumes the total
//   out_sum    batch total (zero when no result is presented)
//   out_ovf    accumulator carried out during this batch
// -----------------------------------------------------------------------------
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int                CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0]  N_CNT = CNT_W'(N);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  state_t             w_state_next;
  logic [ACC_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_ovf_next;

  logic               w_in_ready;
  logic               w_beat_acc;
  logic               w_out_hs;
  logic [ACC_W-1:0]   w_beat_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_upd;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Bit 3 of the adder word is always zero upstream and carries no data.
  logic               w_unused_in_data;
  assign w_unused_in_data = in_data[3];

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign w_in_ready = (r_state != ST_DONE);
  assign w_beat_acc = in_valid && w_in_ready;
  assign w_out_hs   = (r_state == ST_DONE) && out_ready;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign w_beat_ext = {{(ACC_W-BEAT_W){1'b0}}, in_data[BEAT_W-1:0]};

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .i_acc   (r_acc),
    .i_beat  (w_beat_ext),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

`ifdef SUM_ACCUM_SAT_EN
  // Once the batch has overflowed, keep the accumulator pinned at all-ones
  // so later small beats cannot make the total look plausible again.
  assign w_acc_upd = (r_ovf || w_carry) ? {ACC_W{1'b1}} : w_sum;
`else
  assign w_acc_upd = w_sum;
`endif

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state / next-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;

    unique case (r_state)
      ST_IDLE, ST_ACCUM: begin
        // IDLE always holds acc=0/count=0, so a beat there starts the batch
        // with the same update used in ACCUM. With N==1 the incremented
        // count already equals N and the FSM skips ACCUM.
        if (w_beat_acc) begin
          w_acc_next = w_acc_upd;
          w_ovf_next = r_ovf | w_carry;
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == N_CNT) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_ACCUM;
          end
        end
      end

      ST_DONE: begin
        if (w_out_hs) begin
          w_state_next = ST_IDLE;
          w_acc_next   = '0;
          w_cnt_next   = '0;
          w_ovf_next   = 1'b0;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_acc_next   = '0;
        w_cnt_next   = '0;
        w_ovf_next   = 1'b0;
      end
    endcase

    // Abort wins over any beat or output handshake in the same cycle.
    if (clr) begin
      w_state_next = ST_IDLE;
      w_acc_next   = '0;
      w_cnt_next   = '0;
      w_ovf_next   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The result is only presented in DONE; in the other states the partial
  // accumulator is hidden so downstream never sees a moving value.
  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign out_sum   = (r_state == ST_DONE) ? r_acc : '0;
  assign out_ovf   = (r_state == ST_DONE) && r_ovf;

endmodule : sum_accum

// File: tb/tb_sum_accum.sv
`timescale 1ns/1ps
module tb_sum_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance (N=4, ACC_W=8)
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_ovf;

  // 4-bit instance (N=4, ACC_W=4) for overflow behaviour
  logic       clr4 = 1'b0;
  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] in_data4 = 4'd0;
  logic       out_valid4;
  logic       out_ready4 = 1'b0;
  logic [3:0] out_sum4;
  logic       out_ovf4;

  sum_accum #(.N(4), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  sum_accum #(.N(4), .ACC_W(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_ovf(out_ovf4)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic [3:0] b0, b1, b2, b3;
    int         gap;        // idle cycles after each beat
    logic [7:0] exp_sum;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one beat on the 8-bit DUT; entered and left at posedge+1.
  task automatic beat(input string name, input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Four beats with optional gaps, then exact-latency result check and drain.
  task automatic run_batch(input string name, input logic [3:0] b0, input logic [3:0] b1,
                           input logic [3:0] b2, input logic [3:0] b3, input int gap,
                           input logic [7:0] exp_sum, input logic exp_ovf);
    logic [3:0] bl[4];
    bl[0] = b0; bl[1] = b1; bl[2] = b2; bl[3] = b3;
    for (int i = 0; i < 4; i++) begin
      beat(name, bl[i]);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check({name, ".no_early_valid"}, 32'(out_valid), 32'd0);
          idle_cycle();
        end
      end
    end
    @(negedge clk);
    check({name, ".out_valid"}, 32'(out_valid), 32'd1);
    check({name, ".out_sum"},   32'(out_sum),   32'(exp_sum));
    check({name, ".out_ovf"},   32'(out_ovf),   32'(exp_ovf));
    check({name, ".in_ready_done"}, 32'(in_ready), 32'd0);
    $display("[TB] batch %s: sum=%0d ovf=%0d (expected %0d/%0d)", name, out_sum, out_ovf, exp_sum, exp_ovf);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, ".drain_valid"}, 32'(out_valid), 32'd0);
    check({name, ".drain_ready"}, 32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] b4[4];
    logic [3:0] exp4;

    vecs[0] = '{"b2b_six",   4'd6,  4'd6,  4'd6,  4'd6, 0, 8'd24, 1'b0};
    vecs[1] = '{"ramp",      4'd1,  4'd2,  4'd3,  4'd0, 0, 8'd6,  1'b0};
    vecs[2] = '{"bit3_gaps", 4'hE,  4'hE,  4'hE,  4'hE, 2, 8'd24, 1'b0};
    vecs[3] = '{"zeros",     4'd0,  4'd0,  4'd0,  4'd0, 1, 8'd0,  1'b0};
    vecs[4] = '{"fives",     4'd5,  4'd4,  4'd5,  4'd6, 1, 8'd20, 1'b0};

    // Reset state
    #2;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_sum",   32'(out_sum),   32'd0);
    check("rst.out_ovf",   32'(out_ovf),   32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();

    // Table-driven batches
    for (int v = 0; v < 5; v++) begin
      run_batch(vecs[v].name, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3,
                vecs[v].gap, vecs[v].exp_sum, vecs[v].exp_ovf);
    end

    // Mid-batch reset discards the partial batch
    beat("mrst", 4'd1);
    beat("mrst", 4'd1);
    rst = 1'b1;
    #2;
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.out_sum",   32'(out_sum),   32'd0);
    check("mrst.out_ovf",   32'(out_ovf),   32'd0);
    check("mrst.in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_batch("after_rst", 4'd1, 4'd1, 4'd1, 4'd1, 0, 8'd4, 1'b0);

    // Backpressure: result held, offered beats ignored
    for (int i = 0; i < 4; i++) beat("bp", 4'd6);
    in_valid = 1'b1;
    in_data  = 4'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.out_sum",   32'(out_sum),   32'd24);
      check("bp.in_ready",  32'(in_ready),  32'd0);
      idle_cycle();
    end
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp.release_valid", 32'(out_valid), 32'd0);
    check("bp.release_ready", 32'(in_ready),  32'd1);
    $display("[TB] backpressure batch released");
    idle_cycle();
    run_batch("post_bp", 4'd1, 4'd1, 4'd1, 4'd1, 0, 8'd4, 1'b0);

    // clr with a simultaneous beat: beat dropped, batch restarted
    beat("clr", 4'd5);
    beat("clr", 4'd5);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd5;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    @(negedge clk);
    check("clr.out_valid", 32'(out_valid), 32'd0);
    check("clr.in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    run_batch("after_clr", 4'd1, 4'd2, 4'd3, 4'd0, 0, 8'd6, 1'b0);

    // ACC_W=4 overflow: 6+6+6 carries out of 4 bits
`ifdef SUM_ACCUM_SAT_EN
    exp4 = 4'd15;
`else
    exp4 = 4'd2;
`endif
    b4[0] = 4'd6; b4[1] = 4'd6; b4[2] = 4'd6; b4[3] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1'b1;
      in_data4  = b4[i];
      @(negedge clk);
      check("w4.in_ready", 32'(in_ready4), 32'd1);
      check("w4.no_early_valid", 32'(out_valid4), 32'd0);
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      in_data4  = 4'd0;
    end
    @(negedge clk);
    check("w4.out_valid", 32'(out_valid4), 32'd1);
    check("w4.out_sum",   32'(out_sum4),   32'(exp4));
    check("w4.out_ovf",   32'(out_ovf4),   32'd1);
    $display("[TB] batch acc4_ovf: sum=%0d ovf=%0d (expected %0d/1)", out_sum4, out_ovf4, exp4);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    @(negedge clk);
    check("w4.drain_valid", 32'(out_valid4), 32'd0);
    check("w4.drain_ovf",   32'(out_ovf4),   32'd0);
    check("w4.drain_ready", 32'(in_ready4),  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_sum_accum
